// File: rtl/PARAMS_pkg.sv
// rtl/PARAMS_pkg.sv - shared widths, opcodes and ALU request record
package PARAMS_pkg;

    localparam int WD_SIZE     = 32;
    localparam int OPCODE_BITS = 7;
    localparam int FUNCT7_BITS = 7;
    localparam int FUNCT3_BITS = 3;
    localparam int NUM_ALU_REQ = 2;

    localparam logic [OPCODE_BITS-1:0] OPC_R  = 7'b0110011;
    localparam logic [OPCODE_BITS-1:0] OPC_BR = 7'b1100011;
    localparam logic [FUNCT7_BITS-1:0] ADDS   = 7'b0000000;
    localparam logic [FUNCT7_BITS-1:0] SUBS   = 7'b0100000;

    // One requester's view of an ALU operation, muxed as a unit onto the ALU
    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [FUNCT7_BITS-1:0] funct7;
        logic [FUNCT3_BITS-1:0] funct3;
        logic [WD_SIZE-1:0]     op1;
        logic [WD_SIZE-1:0]     op2;
    } alu_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter owning the priority pointer
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic prio_q;
    logic prio_d;

    // Pick the lone eligible requester, or prio on a tie; idle id points at prio
    always_comb begin
        gnt_id = prio_q;
        gnt    = 2'b00;
        prio_d = prio_q;
        case (elig)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = prio_q;
        endcase
        if (elig != 2'b00) begin
            gnt[gnt_id] = 1'b1;
            prio_d      = ~gnt_id;
        end
    end

    // Priority pointer moves to the other requester after every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with registered responses
module alu_arbiter
    import PARAMS_pkg::*;
#(
    parameter int WD_SIZE = PARAMS_pkg::WD_SIZE,
    parameter int NUM_REQ = NUM_ALU_REQ
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0][OPCODE_BITS-1:0]    req_opcode,
    input  logic [NUM_REQ-1:0][FUNCT7_BITS-1:0]    req_funct7,
    input  logic [NUM_REQ-1:0][FUNCT3_BITS-1:0]    req_funct3,
    input  logic [NUM_REQ-1:0][WD_SIZE-1:0]        req_op1,
    input  logic [NUM_REQ-1:0][WD_SIZE-1:0]        req_op2,
    input  logic [NUM_REQ-1:0]                     flush,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output logic [NUM_REQ-1:0][WD_SIZE-1:0]        rsp_result,
    output logic [NUM_REQ-1:0]                     rsp_zero,
    output logic [OPCODE_BITS-1:0]                 alu_opcode,
    output logic [FUNCT7_BITS-1:0]                 alu_funct7,
    output logic [FUNCT3_BITS-1:0]                 alu_funct3,
    output logic [WD_SIZE-1:0]                     alu_op1,
    output logic [WD_SIZE-1:0]                     alu_op2,
    input  logic [WD_SIZE-1:0]                     alu_result,
    input  logic                                   alu_zero,
    output logic                                   grant_id
);

    logic [NUM_REQ-1:0]              elig;
    logic [NUM_REQ-1:0]              gnt;
    logic                            gnt_id;
    alu_req_t                        reqs [NUM_REQ];
    alu_req_t                        sel;

    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][WD_SIZE-1:0] rsp_result_q, rsp_result_d;
    logic [NUM_REQ-1:0]              rsp_zero_q, rsp_zero_d;

    // A requester may compete only if its response slot is free or draining now;
    // reset blocks all acceptance so nothing is handed out while state is cleared
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = ~reset & req_valid[i] & ~flush[i]
                    & (~rsp_valid_q[i] | rsp_ready[i]);
        end
    end

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .elig   (elig),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Gather each requester's fields and steer the selected one onto the ALU
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].opcode = req_opcode[i];
            reqs[i].funct7 = req_funct7[i];
            reqs[i].funct3 = req_funct3[i];
            reqs[i].op1    = req_op1[i];
            reqs[i].op2    = req_op2[i];
        end
        sel        = reqs[gnt_id];
        alu_opcode = sel.opcode;
        alu_funct7 = sel.funct7;
        alu_funct3 = sel.funct3;
        alu_op1    = sel.op1;
        alu_op2    = sel.op2;
    end

    // Load on grant (covers drain+reload); otherwise flush or drain empties the slot
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rsp_valid_d[i]  = 1'b1;
                rsp_result_d[i] = alu_result;
                rsp_zero_d[i]   = alu_zero;
            end else if (flush[i] || (rsp_valid_q[i] && rsp_ready[i])) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    // Response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign req_ready  = gnt;
    assign grant_id   = gnt_id;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter
module tb_alu_arbiter;
    import PARAMS_pkg::*;

    logic                                clk;
    logic                                reset;
    logic [1:0]                          req_valid;
    logic [1:0]                          req_ready;
    logic [1:0][OPCODE_BITS-1:0]         req_opcode;
    logic [1:0][FUNCT7_BITS-1:0]         req_funct7;
    logic [1:0][FUNCT3_BITS-1:0]         req_funct3;
    logic [1:0][WD_SIZE-1:0]             req_op1;
    logic [1:0][WD_SIZE-1:0]             req_op2;
    logic [1:0]                          flush;
    logic [1:0]                          rsp_valid;
    logic [1:0]                          rsp_ready;
    logic [1:0][WD_SIZE-1:0]             rsp_result;
    logic [1:0]                          rsp_zero;
    logic [OPCODE_BITS-1:0]              alu_opcode;
    logic [FUNCT7_BITS-1:0]              alu_funct7;
    logic [FUNCT3_BITS-1:0]              alu_funct3;
    logic [WD_SIZE-1:0]                  alu_op1;
    logic [WD_SIZE-1:0]                  alu_op2;
    logic [WD_SIZE-1:0]                  alu_result;
    logic                                alu_zero;
    logic                                grant_id;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_funct7 (req_funct7),
        .req_funct3 (req_funct3),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_opcode (alu_opcode),
        .alu_funct7 (alu_funct7),
        .alu_funct3 (alu_funct3),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: branch compares and SUBS subtract, everything else adds
    always_comb begin
        if (alu_opcode == OPC_BR || alu_funct7 == SUBS) alu_result = alu_op1 - alu_op2;
        else                                            alu_result = alu_op1 + alu_op2;
        alu_zero = (alu_result == '0);
    end

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  fl;
        logic [1:0]  rr;
        logic [1:0]  br;
        logic [1:0]  sub;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  rdy;
        logic        gid;
        logic [1:0]  rv;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [1:0]  z;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t t);
        req_valid = t.v;
        flush     = t.fl;
        rsp_ready = t.rr;
        for (int i = 0; i < 2; i++) begin
            req_opcode[i] = t.br[i] ? OPC_BR : OPC_R;
            req_funct7[i] = t.sub[i] ? SUBS : ADDS;
            req_funct3[i] = 3'b000;
        end
        req_op1[0] = t.a0;
        req_op2[0] = t.b0;
        req_op1[1] = t.a1;
        req_op2[1] = t.b1;
    endtask

    initial begin
        vec_t idle;
        idle = '0;
        // v    fl     rr     br     sub    a0      b0      a1      b1      rdy    gid   rv     r0      r1      z
        // contention from reset: 0,1,0,1 with rsp_ready held high
        vecs.push_back('{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 32'd5, 32'd7, 32'd10, 32'd3, 2'b01, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        vecs.push_back('{2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 32'd1, 32'd1, 32'd10, 32'd3, 2'b10, 1'b1, 2'b01, 32'd12, 32'd0,  2'b00});
        vecs.push_back('{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 32'd1, 32'd1, 32'd4,  32'd4, 2'b01, 1'b0, 2'b10, 32'd0,  32'd7,  2'b00});
        vecs.push_back('{2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 32'd2, 32'd2, 32'd4,  32'd4, 2'b10, 1'b1, 2'b01, 32'd2,  32'd0,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b10, 32'd0,  32'd8,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        // single request on port 0, held response blocks the next request until drained
        vecs.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0,  32'd0, 2'b01, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        vecs.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0,  32'd0, 2'b00, 1'b1, 2'b01, 32'd12, 32'd0,  2'b00});
        vecs.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0,  32'd0, 2'b00, 1'b1, 2'b01, 32'd12, 32'd0,  2'b00});
        vecs.push_back('{2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0,  32'd0, 2'b01, 1'b0, 2'b01, 32'd12, 32'd0,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b1, 2'b01, 32'd2,  32'd0,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b1, 2'b00, 32'd0,  32'd0,  2'b00});
        // port 1 back-to-back drain+reload: 1, 2, 3
        vecs.push_back('{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd1, 2'b10, 1'b1, 2'b00, 32'd0,  32'd0,  2'b00});
        vecs.push_back('{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1,  32'd1, 2'b10, 1'b1, 2'b10, 32'd0,  32'd1,  2'b00});
        vecs.push_back('{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1,  32'd2, 2'b10, 1'b1, 2'b10, 32'd0,  32'd2,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b10, 32'd0,  32'd3,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        // flush with a same-cycle request on port 0, port 1 wins; then flush beats drain
        vecs.push_back('{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'd2, 32'd3, 32'd0,  32'd0, 2'b01, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        vecs.push_back('{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 32'd1, 32'd1, 32'd6,  32'd6, 2'b10, 1'b1, 2'b01, 32'd5,  32'd0,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b10, 32'd0,  32'd12, 2'b00});
        vecs.push_back('{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b10, 32'd0,  32'd12, 2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        // branch compare with equal operands sets the zero flag
        vecs.push_back('{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 32'd9, 32'd9, 32'd0,  32'd0, 2'b01, 1'b0, 2'b00, 32'd0,  32'd0,  2'b00});
        vecs.push_back('{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,  32'd0, 2'b00, 1'b1, 2'b01, 32'd0,  32'd0,  2'b01});

        // reset state, with requests pending to show nothing is accepted under reset
        drive(idle);
        req_valid = 2'b11;
        reset = 1'b1;
        #2;
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_result0", rsp_result[0], 32'd0);
        check("reset rsp_result1", rsp_result[1], 32'd0);
        check("reset rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        drive(idle);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r]);
            @(negedge clk);
            check($sformatf("row%0d req_ready", r), 32'(req_ready), 32'(vecs[r].rdy));
            check($sformatf("row%0d grant_id", r), 32'(grant_id), 32'(vecs[r].gid));
            check($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(vecs[r].rv));
            if (vecs[r].rv[0]) begin
                check($sformatf("row%0d rsp_result0", r), rsp_result[0], vecs[r].r0);
                check($sformatf("row%0d rsp_zero0", r), 32'(rsp_zero[0]), 32'(vecs[r].z[0]));
            end
            if (vecs[r].rv[1]) begin
                check($sformatf("row%0d rsp_result1", r), rsp_result[1], vecs[r].r1);
                check($sformatf("row%0d rsp_zero1", r), 32'(rsp_zero[1]), 32'(vecs[r].z[1]));
            end
            @(posedge clk);
            #1;
        end

        // fill port 1 too so both response registers are full, then reset between edges
        drive(idle);
        req_valid  = 2'b10;
        req_op1[1] = 32'd20;
        req_op2[1] = 32'd22;
        @(negedge clk);
        check("fill req_ready", 32'(req_ready), 32'b10);
        @(posedge clk);
        #1;
        drive(idle);
        #1;
        check("prefill rsp_valid", 32'(rsp_valid), 32'b11);
        check("prefill rsp_result1", rsp_result[1], 32'd42);
        reset      = 1'b1;
        req_valid  = 2'b11;
        rsp_ready  = 2'b11;
        req_op1[0] = 32'd5;
        req_op2[0] = 32'd7;
        req_op1[1] = 32'd1;
        req_op2[1] = 32'd2;
        #1;
        check("async rsp_valid", 32'(rsp_valid), 32'd0);
        check("async rsp_result0", rsp_result[0], 32'd0);
        check("async rsp_result1", rsp_result[1], 32'd0);
        check("async rsp_zero", 32'(rsp_zero), 32'd0);
        check("async req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("held reset rsp_valid", 32'(rsp_valid), 32'd0);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("post-reset req_ready", 32'(req_ready), 32'b01);
        check("post-reset grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        check("post-reset next req_ready", 32'(req_ready), 32'b10);
        check("post-reset rsp_valid", 32'(rsp_valid), 32'b01);
        check("post-reset rsp_result0", rsp_result[0], 32'd12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
